// File: rtl/vp_line_scheduler_pkg.sv
// rtl/vp_line_scheduler_pkg.sv - shared constants and state encoding for the line scheduler
package vp_line_scheduler_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Width of the column index carried alongside each charattr word
  localparam int COL_W = 7;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

endpackage

// File: rtl/vp_delay_line.sv
// rtl/vp_delay_line.sv - width x depth shift register with synchronous clear
module vp_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  // Shift one stage per cycle; reset empties the whole line so no stale entries emerge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vp_line_scheduler.sv
// rtl/vp_line_scheduler.sv - per-scanline charattr fetch and row/ypos tracking for vp_pipeline
module vp_line_scheduler
  import vp_line_scheduler_pkg::*;
#(
  parameter int COLUMNS      = 80,
  parameter int CHAR_HEIGHT  = 20,
  parameter int PIPE_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic [15:0] base_address,
  output logic        mem_request,
  output logic [15:0] mem_address,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [31:0] charattr,
  output logic [4:0]  char_row_in,
  output logic [3:0]  ypos,
  output logic        enabled,
  output logic [6:0]  wr_column,
  output logic        wr_enable,
  output logic        busy,
  output logic        line_done,
  output logic        overrun
);

  state_t      state;
  logic [6:0]  column;
  logic [6:0]  en_column;
  logic [4:0]  char_row;
  logic [15:0] text_row;
  logic [3:0]  ypos_count;
  logic [15:0] row_offset;
  logic        last_col;
  logic [COL_W:0] dl_in;
  logic [COL_W:0] dl_out;

  // Address arithmetic wraps at 16 bits, so truncating the product is intended
  assign row_offset = text_row * 16'(COLUMNS);
  assign last_col   = (column == 7'(COLUMNS - 1));

  // Line FSM: start, per-column fetch, frame restart/abort and the frame counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      column      <= '0;
      en_column   <= '0;
      char_row    <= '0;
      text_row    <= '0;
      ypos_count  <= '0;
      mem_request <= FALSE;
      mem_address <= '0;
      charattr    <= '0;
      char_row_in <= '0;
      ypos        <= '0;
      enabled     <= FALSE;
      busy        <= FALSE;
      line_done   <= FALSE;
      overrun     <= FALSE;
    end else begin
      enabled   <= FALSE;
      line_done <= FALSE;

      if (frame_start) begin
        char_row   <= '0;
        text_row   <= '0;
        ypos_count <= '0;
        overrun    <= FALSE;
      end else if (line_start && state == S_FETCH) begin
        overrun <= TRUE;
      end

      if (line_start && (state == S_IDLE || frame_start)) begin
        // A same-cycle frame_start means the line begins at row 0 regardless of the old counters
        state       <= S_FETCH;
        column      <= '0;
        mem_request <= TRUE;
        busy        <= TRUE;
        mem_address <= base_address + (frame_start ? 16'd0 : row_offset);
      end else if (frame_start) begin
        state       <= S_IDLE;
        mem_request <= FALSE;
        busy        <= FALSE;
      end else if (state == S_FETCH && mem_ack) begin
        charattr    <= mem_data;
        enabled     <= TRUE;
        char_row_in <= char_row;
        ypos        <= ypos_count;
        en_column   <= column;
        if (last_col) begin
          state       <= S_IDLE;
          mem_request <= FALSE;
          busy        <= FALSE;
          line_done   <= TRUE;
          ypos_count  <= ypos_count + 4'd1;
          if (char_row == 5'(CHAR_HEIGHT - 1)) begin
            char_row <= '0;
            text_row <= text_row + 16'd1;
          end else begin
            char_row <= char_row + 5'd1;
          end
        end else begin
          column      <= column + 7'd1;
          mem_address <= mem_address + 16'd1;
        end
      end
    end
  end

  assign dl_in = {enabled, en_column};

  vp_delay_line #(
    .WIDTH(COL_W + 1),
    .DEPTH(PIPE_LATENCY)
  ) u_delay (
    .clk  (clk),
    .reset(reset),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign wr_enable = dl_out[COL_W];
  assign wr_column = dl_out[COL_W-1:0];

endmodule

// File: tb/tb_vp_line_scheduler.sv
// tb/tb_vp_line_scheduler.sv - directed self-checking bench for vp_line_scheduler
module tb_vp_line_scheduler;

  localparam int COLUMNS      = 4;
  localparam int CHAR_HEIGHT  = 3;
  localparam int PIPE_LATENCY = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        line_start;
  logic [15:0] base_address;
  logic        mem_request;
  logic [15:0] mem_address;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [31:0] charattr;
  logic [4:0]  char_row_in;
  logic [3:0]  ypos;
  logic        enabled;
  logic [6:0]  wr_column;
  logic        wr_enable;
  logic        busy;
  logic        line_done;
  logic        overrun;
  logic [69:0] outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: each word is tagged with its own address
  assign mem_data = {16'hA5A5, mem_address};
  assign outs = {mem_request, mem_address, charattr, char_row_in, ypos, enabled,
                 wr_column, wr_enable, busy, line_done, overrun};

  vp_line_scheduler #(
    .COLUMNS(COLUMNS),
    .CHAR_HEIGHT(CHAR_HEIGHT),
    .PIPE_LATENCY(PIPE_LATENCY)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
    .base_address(base_address), .mem_request(mem_request), .mem_address(mem_address),
    .mem_ack(mem_ack), .mem_data(mem_data), .charattr(charattr), .char_row_in(char_row_in),
    .ypos(ypos), .enabled(enabled), .wr_column(wr_column), .wr_enable(wr_enable),
    .busy(busy), .line_done(line_done), .overrun(overrun)
  );

  function automatic logic [31:0] word(input logic [15:0] a);
    return {16'hA5A5, a};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; mem_ack = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    checks++;
    if (outs !== 70'd0) begin
      errors++; $display("FAIL reset_outputs got %h want %h", outs, 70'd0);
    end
  endtask

  task automatic test_zero_wait;
    logic exp_req, exp_en, exp_wr;
    apply_reset;
    mem_ack = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      line_start = (c == 10);
      exp_req = (c >= 11 && c <= 14);
      exp_en  = (c >= 12 && c <= 15);
      exp_wr  = (c >= 15 && c <= 18);
      checks++;
      if ({mem_request, busy} !== {exp_req, exp_req}) begin
        errors++; $display("FAIL zw_req c%0d got %b%b want %b", c, mem_request, busy, exp_req);
      end
      if (exp_req) begin
        checks++;
        if (mem_address !== 16'h0100 + 16'(c - 11)) begin
          errors++; $display("FAIL zw_addr c%0d got %h want %h", c, mem_address, 16'h0100 + 16'(c - 11));
        end
      end
      checks++;
      if (enabled !== exp_en) begin
        errors++; $display("FAIL zw_en c%0d got %b want %b", c, enabled, exp_en);
      end
      if (exp_en) begin
        checks++;
        if ({charattr, char_row_in} !== {word(16'h0100 + 16'(c - 12)), 5'd0}) begin
          errors++; $display("FAIL zw_data c%0d got %h/%0d want %h/0", c, charattr, char_row_in, word(16'h0100 + 16'(c - 12)));
        end
      end
      checks++;
      if (line_done !== (c == 15)) begin
        errors++; $display("FAIL zw_done c%0d got %b want %b", c, line_done, (c == 15));
      end
      checks++;
      if (wr_enable !== exp_wr) begin
        errors++; $display("FAIL zw_wr_en c%0d got %b want %b", c, wr_enable, exp_wr);
      end
      if (exp_wr) begin
        checks++;
        if (wr_column !== 7'(c - 15)) begin
          errors++; $display("FAIL zw_wr_col c%0d got %0d want %0d", c, wr_column, c - 15);
        end
      end
      tick;
    end
    line_start = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic test_wait_states;
    int req_cnt = 0;
    int n_en = 0;
    bit done = 0;
    logic [15:0] exp_addr = 16'h0100;
    apply_reset;
    line_start = 1'b1; tick; line_start = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (enabled) begin
        checks++;
        if (charattr !== word(16'h0100 + 16'(n_en))) begin
          errors++; $display("FAIL ws_data n%0d got %h want %h", n_en, charattr, word(16'h0100 + 16'(n_en)));
        end
        n_en++;
      end
      if (line_done) done = 1;
      if (mem_request) begin
        checks++;
        if (mem_address !== exp_addr) begin
          errors++; $display("FAIL ws_addr c%0d got %h want %h", c, mem_address, exp_addr);
        end
        req_cnt++;
        mem_ack = (req_cnt % 3 == 0);
        if (mem_ack) exp_addr = exp_addr + 16'd1;
      end else begin
        mem_ack = 1'b0;
      end
      tick;
    end
    mem_ack = 1'b0;
    checks++;
    if (n_en != 4 || !done) begin
      errors++; $display("FAIL ws_count got %0d done %0d want 4 done 1", n_en, done);
    end
  endtask

  task automatic test_counter_wrap;
    apply_reset;
    mem_ack = 1'b1;
    for (int l = 0; l < 4; l++) begin
      int k = 0;
      int rq = 0;
      bit done = 0;
      logic [15:0] lbase = 16'h0100 + 16'((l / CHAR_HEIGHT) * COLUMNS);
      line_start = 1'b1; tick; line_start = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        if (mem_request) begin
          checks++;
          if (mem_address !== lbase + 16'(rq)) begin
            errors++; $display("FAIL cw_addr l%0d got %h want %h", l, mem_address, lbase + 16'(rq));
          end
          rq++;
        end
        if (enabled) begin
          checks++;
          if ({charattr, char_row_in, ypos} !== {word(lbase + 16'(k)), 5'(l % CHAR_HEIGHT), 4'(l)}) begin
            errors++; $display("FAIL cw_data l%0d k%0d got %h/%0d/%0d want %h/%0d/%0d", l, k,
                               charattr, char_row_in, ypos, word(lbase + 16'(k)), l % CHAR_HEIGHT, l);
          end
          k++;
        end
        if (line_done) done = 1;
        tick;
      end
      checks++;
      if (k != 4 || !done) begin
        errors++; $display("FAIL cw_count l%0d got %0d done %0d want 4 done 1", l, k, done);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_overrun;
    int n_en = 0;
    bit done = 0;
    apply_reset;
    mem_ack = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      line_start = (c == 0 || c == 2);
      if (c == 3) begin
        checks++;
        if (overrun !== 1'b1) begin
          errors++; $display("FAIL ov_set got %b want 1", overrun);
        end
      end
      if (enabled) begin
        checks++;
        if (charattr !== word(16'h0100 + 16'(n_en))) begin
          errors++; $display("FAIL ov_data got %h want %h", charattr, word(16'h0100 + 16'(n_en)));
        end
        n_en++;
      end
      if (line_done) done = 1;
      tick;
    end
    line_start = 1'b0;
    checks++;
    if (n_en != 4 || !done || overrun !== 1'b1) begin
      errors++; $display("FAIL ov_line got %0d done %0d ov %b want 4 1 1", n_en, done, overrun);
    end
    frame_start = 1'b1; tick; frame_start = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ov_clear got %b want 0", overrun);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_abort;
    bit done = 0;
    bit ld_seen = 0;
    int n = 0;
    apply_reset;
    mem_ack = 1'b1;
    line_start = 1'b1; tick; line_start = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (line_done) done = 1;
      tick;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL ab_first_line got done 0 want 1");
    end
    for (int c = 0; c < 12; c++) begin
      line_start  = (c == 0);
      frame_start = (c == 3);
      if (c == 3) begin
        checks++;
        if ({enabled, char_row_in} !== {1'b1, 5'd1}) begin
          errors++; $display("FAIL ab_pre got %b/%0d want 1/1", enabled, char_row_in);
        end
      end
      if (c == 4) begin
        checks++;
        if ({mem_request, busy, enabled} !== 3'b000) begin
          errors++; $display("FAIL ab_stop got %b%b%b want 000", mem_request, busy, enabled);
        end
      end
      if (line_done) ld_seen = 1;
      tick;
    end
    line_start = 1'b0; frame_start = 1'b0;
    checks++;
    if (ld_seen) begin
      errors++; $display("FAIL ab_no_done got 1 want 0");
    end
    done = 0;
    line_start = 1'b1; tick; line_start = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (enabled) begin
        checks++;
        if ({charattr, char_row_in, ypos} !== {word(16'h0100 + 16'(n)), 5'd0, 4'd0}) begin
          errors++; $display("FAIL ab_next got %h/%0d/%0d want %h/0/0", charattr, char_row_in, ypos, word(16'h0100 + 16'(n)));
        end
        n++;
      end
      if (line_done) done = 1;
      tick;
    end
    checks++;
    if (n != 4 || !done) begin
      errors++; $display("FAIL ab_next_count got %0d done %0d want 4 1", n, done);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_simultaneous_and_reset;
    bit done = 0;
    apply_reset;
    mem_ack = 1'b1;
    line_start = 1'b1; tick; line_start = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (line_done) done = 1;
      tick;
    end
    frame_start = 1'b1; line_start = 1'b1; tick;
    frame_start = 1'b0; line_start = 1'b0;
    checks++;
    if ({mem_request, mem_address} !== {1'b1, 16'h0100}) begin
      errors++; $display("FAIL sim_start got %b/%h want 1/0100", mem_request, mem_address);
    end
    tick;
    checks++;
    if ({enabled, charattr, char_row_in, ypos} !== {1'b1, word(16'h0100), 5'd0, 4'd0}) begin
      errors++; $display("FAIL sim_data got %b/%h/%0d/%0d want 1/%h/0/0", enabled, charattr, char_row_in, ypos, word(16'h0100));
    end
    tick;
    reset = 1'b1; tick; reset = 1'b0;
    checks++;
    if (outs !== 70'd0) begin
      errors++; $display("FAIL mid_reset got %h want %h", outs, 70'd0);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if ({wr_enable, line_done, mem_request, enabled} !== 4'b0000) begin
        errors++; $display("FAIL post_reset c%0d got %b%b%b%b want 0000", c, wr_enable, line_done, mem_request, enabled);
      end
      tick;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    base_address = 16'h0100;
    reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; mem_ack = 1'b0;
    test_reset;
    test_zero_wait;
    test_wait_states;
    test_counter_wrap;
    test_overrun;
    test_abort;
    test_simultaneous_and_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
